decode_issue: RTL
=================

# decode_issue

Decode-and-issue stage directly upstream of the 32×32 register file. Takes raw RV32I instruction words from fetch and extracts the `rs1`/`rs2`/`rd` indices, sign-extended immediate and operation class. A pending-write scoreboard holds back any instruction with a RAW or WAW hazard. Issued instructions are presented to the register-file/execute stage through a one-entry valid/ready output register.

## Interface
- `NREGS`, 32: architectural register count (x0 hard-wired zero).
- `AW`, 5: register index width, log2(`NREGS`).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_valid`  in  1: fetch presents `in_instr`.
- `in_ready`  out  1: stage accepts `in_instr` this cycle.
- `in_instr`  in  32: RV32I instruction word.
- `out_valid`  out  1: decoded instruction held for downstream.
- `out_ready`  in  1: downstream consumes the held instruction.
- `out_rs1`, `out_rs2`, `out_rd`  out  AW each: register indices; unused fields are 0.
- `out_we`  out  1: instruction writes `out_rd`; always 0 when `out_rd` = 0.
- `out_imm`  out  32: sign-extended immediate; 0 for R-type.
- `out_opclass`  out  4: ALU_R, ALU_I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, ILLEGAL.
- `wb_valid`  in  1: writeback completes this cycle.
- `wb_rd`  in  AW: register being written back.
- `flush`  in  1: discard the held instruction; takes priority over issue.

## Operation
- Decoding is combinational from `opcode[6:0]`:
  - `rs1` is used by ALU_R, ALU_I, LOAD, STORE, BRANCH and JALR.
  - `rs2` is used by ALU_R, STORE and BRANCH.
  - `rd` is written by every class except STORE, BRANCH and ILLEGAL.
- Immediate formats: I, S, B, U and J per RV32I, sign-extended from bit 31.
- An unknown opcode is ILLEGAL. It issues normally with `we`=0, all indices 0 and imm 0.
- Scoreboard: `pending[NREGS-1:0]`. Bit 0 is never set.
- Effective pending mask: `eff = pending & ~(wb_valid ? onehot(wb_rd) : 0)`. A same-cycle writeback releases a stall.
- Hazard: a used source is in `eff`, or `we` is set and `rd` is in `eff` (WAW).
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- Issue occurs when `in_valid && in_ready`:
  - Load the output register and set `out_valid`.
  - If `we`, set `pending[rd]`.
- Set versus clear on the same index in the same cycle: set wins.
- Accept without a new issue clears `out_valid`.
- Flush:
  - `out_valid` goes to 0 next cycle.
  - If the flushed instruction had `out_we`, clear `pending[out_rd]`, since its writeback will never arrive.
  - Instructions already accepted downstream are unaffected.
- `wb_valid` with `wb_rd`=0, or for a non-pending register, has no effect.

## Timing
- Reset values: `out_valid`=0, all `out_*` fields 0, `pending`=0. `in_ready` is combinational and is 1 after reset.
- Latency: 1 cycle from the accept edge to `out_valid`. Throughput: 1 instruction per cycle with no hazards and `out_ready`=1.
- The output register holds stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally on `in_instr`, `wb_*`, `out_ready` and `flush`. `out_*` are registered only.
- `rst_n` asserted mid-operation clears all state immediately. There is no partial drain.

## Structure
- Package `rv32_pkg`:
  - opcode constants;
  - `opclass_t` enum (4-bit);
  - immediate-format enum;
  - `NREGS`/`AW` defaults.
- Sub-module `rv32_decode`: purely combinational. Maps instr to {rs1, rs2, rd, used flags, we, imm, opclass}.
- The top level holds the scoreboard, hazard logic and output register.

## Test plan
- Reset, then issue `0x00100293` (ADDI x5,x0,1).
  - Next cycle: `out_valid`=1, rd=5, rs1=0, imm=1, `out_we`=1, opclass ALU_I.
  - `pending[5]`=1.
- Issue `0x00528333` (ADD x6,x5,x5) while x5 is pending.
  - `in_ready`=0 until `wb_valid`=1 with `wb_rd`=5.
  - Accepted in that same cycle; `pending`={6}.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - `out_*` stay unchanged and `in_ready`=0.
  - On release, the next instruction issues on the following edge.
- Issue `0x00512223` (SW x5,4(x2)) with x5 not pending.
  - rs1=2, rs2=5, imm=4, `out_we`=0, opclass STORE.
  - No scoreboard change.
- Held ADDI x7 with `flush`=1.
  - `out_valid`=0 next cycle, `pending[7]`=0, `in_ready`=0 during the flush cycle.
- Issue `0x00000013` (ADDI x0) then `0xFFFFFFFF`.
  - ADDI x0: `out_we`=0, `pending` unchanged.
  - `0xFFFFFFFF`: opclass ILLEGAL, `out_we`=0, imm=0.
  - Assert `rst_n`=0 mid-stall: `pending`=0 and `out_valid`=0 immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I decode definitions.
//   - major opcode constants
//   - opclass_t: 4-bit operation class carried to execute
//   - imm_fmt_t: immediate format selector used inside the decoder
//   - NREGS / AW: default register-file geometry
package rv32_pkg;

   localparam int NREGS = 32;
   localparam int AW    = 5;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_R   = 4'd0,
      ALU_I   = 4'd1,
      LOAD    = 4'd2,
      STORE   = 4'd3,
      BRANCH  = 4'd4,
      LUI     = 4'd5,
      AUIPC   = 4'd6,
      JAL     = 4'd7,
      JALR    = 4'd8,
      ILLEGAL = 4'd9
   } opclass_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_t;

endpackage

// File: rtl/rv32_decode.sv
// rv32_decode: purely combinational RV32I field extraction.
//   i_instr    : raw instruction word
//   o_rs1/rs2  : source indices (0 when the class does not read them)
//   o_use1/2   : source is actually read by this class
//   o_rd       : destination index (0 when the class does not write)
//   o_we       : writes o_rd; never set for rd = x0
//   o_imm      : sign-extended immediate (0 for R-type and ILLEGAL)
//   o_opclass  : operation class
module rv32_decode
   import rv32_pkg::*;
(
   input  logic [31:0]   i_instr,
   output logic [AW-1:0] o_rs1,
   output logic [AW-1:0] o_rs2,
   output logic [AW-1:0] o_rd,
   output logic          o_use1,
   output logic          o_use2,
   output logic          o_we,
   output logic [31:0]   o_imm,
   output opclass_t      o_opclass
);

   logic     w_wr_rd;
   imm_fmt_t w_fmt;

   always_comb begin
      o_opclass = ILLEGAL;
      w_fmt     = IMM_NONE;
      o_use1    = 1'b0;
      o_use2    = 1'b0;
      w_wr_rd   = 1'b0;
      unique case (i_instr[6:0])
         OP_REG:    begin o_opclass = ALU_R;  o_use1 = 1'b1; o_use2 = 1'b1; w_wr_rd = 1'b1; end
         OP_IMM:    begin o_opclass = ALU_I;  o_use1 = 1'b1; w_fmt = IMM_I; w_wr_rd = 1'b1; end
         OP_LOAD:   begin o_opclass = LOAD;   o_use1 = 1'b1; w_fmt = IMM_I; w_wr_rd = 1'b1; end
         OP_STORE:  begin o_opclass = STORE;  o_use1 = 1'b1; o_use2 = 1'b1; w_fmt = IMM_S; end
         OP_BRANCH: begin o_opclass = BRANCH; o_use1 = 1'b1; o_use2 = 1'b1; w_fmt = IMM_B; end
         OP_LUI:    begin o_opclass = LUI;    w_fmt = IMM_U; w_wr_rd = 1'b1; end
         OP_AUIPC:  begin o_opclass = AUIPC;  w_fmt = IMM_U; w_wr_rd = 1'b1; end
         OP_JAL:    begin o_opclass = JAL;    w_fmt = IMM_J; w_wr_rd = 1'b1; end
         OP_JALR:   begin o_opclass = JALR;   o_use1 = 1'b1; w_fmt = IMM_I; w_wr_rd = 1'b1; end
         default:   ;
      endcase
   end

   // Unused index fields are zeroed so downstream never sees stale register numbers.
   assign o_rs1 = o_use1  ? i_instr[19:15] : '0;
   assign o_rs2 = o_use2  ? i_instr[24:20] : '0;
   assign o_rd  = w_wr_rd ? i_instr[11:7]  : '0;
   assign o_we  = w_wr_rd && (i_instr[11:7] != '0);

   always_comb begin
      o_imm = 32'd0;
      unique case (w_fmt)
         IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   o_imm = {i_instr[31:12], 12'd0};
         IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode, pending-write scoreboard and one-entry issue register.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : fetch handshake carrying in_instr
//   out_valid/out_ready  : downstream handshake for the held instruction
//   out_rs1/rs2/rd/we/imm/opclass : registered decoded fields
//   wb_valid/wb_rd       : writeback release of a pending register
//   flush                : discard the held instruction
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1; valid, once raised, holds its payload stable until that edge (or
// until flush discards it); ready may depend combinationally on the payload.
module decode_issue
   import rv32_pkg::*;
#(
   parameter int NREGS = rv32_pkg::NREGS,
   parameter int AW    = rv32_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_rs1,
   output logic [AW-1:0] out_rs2,
   output logic [AW-1:0] out_rd,
   output logic          out_we,
   output logic [31:0]   out_imm,
   output opclass_t      out_opclass,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_rd,
   input  logic          flush
);

   logic [AW-1:0]    w_rs1, w_rs2, w_rd;
   logic             w_use1, w_use2, w_we;
   logic [31:0]      w_imm;
   opclass_t         w_opclass;

   logic [NREGS-1:0] r_pending;
   logic [NREGS-1:0] w_wb_mask;
   logic [NREGS-1:0] w_eff;
   logic [NREGS-1:0] w_pending_nxt;
   logic             w_hazard;
   logic             w_issue;

   rv32_decode u_dec (
      .i_instr   (in_instr),
      .o_rs1     (w_rs1),
      .o_rs2     (w_rs2),
      .o_rd      (w_rd),
      .o_use1    (w_use1),
      .o_use2    (w_use2),
      .o_we      (w_we),
      .o_imm     (w_imm),
      .o_opclass (w_opclass)
   );

   // A writeback in this cycle already frees its register for the incoming instruction.
   assign w_wb_mask = wb_valid ? (NREGS'(1) << wb_rd) : '0;
   assign w_eff     = r_pending & ~w_wb_mask;

   assign w_hazard = (w_use1 && w_eff[w_rs1]) ||
                     (w_use2 && w_eff[w_rs2]) ||
                     (w_we   && w_eff[w_rd]);

   assign in_ready = !flush && !w_hazard && (!out_valid || out_ready);
   assign w_issue  = in_valid && in_ready;

   always_comb begin
      w_pending_nxt = r_pending & ~w_wb_mask;
      // A flushed write will never reach writeback, so release its register.
      // If downstream takes it in the same cycle it is already gone, so keep it pending.
      if (flush && out_valid && out_we && !out_ready)
         w_pending_nxt[out_rd] = 1'b0;
      // Set after clear: a new issue to the same index wins.
      if (w_issue && w_we)
         w_pending_nxt[w_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending   <= '0;
         out_valid   <= 1'b0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_rd      <= '0;
         out_we      <= 1'b0;
         out_imm     <= 32'd0;
         out_opclass <= ALU_R;
      end else begin
         r_pending <= w_pending_nxt;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (w_issue) begin
            out_valid   <= 1'b1;
            out_rs1     <= w_rs1;
            out_rs2     <= w_rs2;
            out_rd      <= w_rd;
            out_we      <= w_we;
            out_imm     <= w_imm;
            out_opclass <= w_opclass;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
